forwarding_controller: RTL

- Sequences the two operand forwarding muxes (select 2 = EX/MEM ALU value, 1 = write-back data, 0 = register-file data) in front of the EX stage.
- Keeps its own shadow pipeline of destination tags (EX, MEM, WB) and from it drives both 2-bit selects.
- Detects load-use hazards, inserts one bubble and raises a stall to the fetch/decode stages.
- Sits beside the ID/EX pipeline register; one instance per issue slot.

---
 rtl/forwarding_controller_pkg.sv | 26 ++
 rtl/forwarding_controller_fwd_select.sv | 30 +++
 rtl/forwarding_controller.sv | 134 +++++++++++++
 3 files changed

// File: rtl/forwarding_controller_pkg.sv
// Shared select encodings and defaults for the EX-stage operand forwarding controller.
package forwarding_controller_pkg;

  localparam int REG_AW_DEFAULT = 5;
  localparam int CNT_W_DEFAULT  = 16;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'd0,
    FWD_WB      = 2'd1,
    FWD_ALU     = 2'd2
  } fwd_sel_e;

  // The MEM hit takes priority because it is the youngest producer of the register.
  function automatic logic [1:0] fwd_encode(input logic mem_hit, input logic wb_hit);
    logic [1:0] sel;
    if (mem_hit) begin
      sel = FWD_ALU;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_REGFILE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/forwarding_controller_fwd_select.sv
// Pure comparator: picks one operand's forwarding select from the MEM and WB destination tags.
module forwarding_controller_fwd_select
  import forwarding_controller_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic              mem_v_i,
  input  logic              mem_rw_i,
  input  logic              mem_mr_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              wb_v_i,
  input  logic              wb_rw_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  output logic [1:0]        sel_o
);

  logic src_nonzero;
  logic mem_hit;
  logic wb_hit;

  assign src_nonzero = (src_i != '0);

  // A load in MEM has no value yet; its match is suppressed so the select falls through to WB.
  assign mem_hit = mem_v_i & mem_rw_i & ~mem_mr_i & src_nonzero & (mem_rd_i == src_i);
  assign wb_hit  = wb_v_i & wb_rw_i & src_nonzero & (wb_rd_i == src_i);

  assign sel_o = fwd_encode(mem_hit, wb_hit);

endmodule

// File: rtl/forwarding_controller.sv
// Shadow EX/MEM/WB tag pipeline driving the operand forwarding selects and the load-use stall.
module forwarding_controller
  import forwarding_controller_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              freeze,
  input  logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  stall_count
);

  logic              ex_v_q,  ex_v_d;
  logic [REG_AW-1:0] ex_rs_q, ex_rs_d;
  logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              ex_rw_q, ex_rw_d;
  logic              ex_mr_q, ex_mr_d;

  logic              mem_v_q;
  logic [REG_AW-1:0] mem_rd_q;
  logic              mem_rw_q;
  logic              mem_mr_q;

  logic              wb_v_q;
  logic [REG_AW-1:0] wb_rd_q;
  logic              wb_rw_q;

  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              insert_bubble;

  assign load_use_stall = id_valid & ex_v_q & ex_mr_q & ex_rw_q & (ex_rd_q != '0)
                        & ((ex_rd_q == id_rs) | (ex_rd_q == id_rt));

  assign insert_bubble = load_use_stall | flush;

  // Bubbles also clear their tags so a dead EX slot can never look like a consumer.
  always_comb begin
    ex_v_d  = id_valid;
    ex_rs_d = id_rs;
    ex_rt_d = id_rt;
    ex_rd_d = id_rd;
    ex_rw_d = id_reg_write;
    ex_mr_d = id_mem_read;
    if (insert_bubble) begin
      ex_v_d  = 1'b0;
      ex_rs_d = '0;
      ex_rt_d = '0;
      ex_rd_d = '0;
      ex_rw_d = 1'b0;
      ex_mr_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (load_use_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_q      <= 1'b0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_rd_q     <= '0;
      ex_rw_q     <= 1'b0;
      ex_mr_q     <= 1'b0;
      mem_v_q     <= 1'b0;
      mem_rd_q    <= '0;
      mem_rw_q    <= 1'b0;
      mem_mr_q    <= 1'b0;
      wb_v_q      <= 1'b0;
      wb_rd_q     <= '0;
      wb_rw_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else if (!freeze) begin
      wb_v_q      <= mem_v_q;
      wb_rd_q     <= mem_rd_q;
      wb_rw_q     <= mem_rw_q;
      mem_v_q     <= ex_v_q;
      mem_rd_q    <= ex_rd_q;
      mem_rw_q    <= ex_rw_q;
      mem_mr_q    <= ex_mr_q;
      ex_v_q      <= ex_v_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_rd_q     <= ex_rd_d;
      ex_rw_q     <= ex_rw_d;
      ex_mr_q     <= ex_mr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;

  logic [REG_AW-1:0] src_tag [2];
  logic [1:0]        sel     [2];

  assign src_tag[0] = ex_rs_q;
  assign src_tag[1] = ex_rt_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_sel
    forwarding_controller_fwd_select #(
      .REG_AW (REG_AW)
    ) u_sel (
      .src_i    (src_tag[gi]),
      .mem_v_i  (mem_v_q),
      .mem_rw_i (mem_rw_q),
      .mem_mr_i (mem_mr_q),
      .mem_rd_i (mem_rd_q),
      .wb_v_i   (wb_v_q),
      .wb_rw_i  (wb_rw_q),
      .wb_rd_i  (wb_rd_q),
      .sel_o    (sel[gi])
    );
  end

  assign fwd_a = sel[0];
  assign fwd_b = sel[1];

endmodule
